// File: rtl/register_status_file.sv
// ---------------------------------------------------------------------------
// register_status_file
//
// Architectural register file that also tracks rename status for each
// register. Every register holds a value, a busy flag and an owner tag (the
// ROB tag of the youngest in-flight writer). It sits between dispatch and
// retirement.
//
// Operations
//   - Dispatch allocations mark destination registers busy under a new owner.
//   - Retirement writes always update the value. They clear busy only when
//     the retiring tag still owns the register, so a stale retire cannot free
//     a register that was re-allocated to a younger instruction.
//   - flush drops all in-flight ownership by clearing every busy flag.
//   - Read ports are registered and hold their outputs while rd_en is low.
//
// Optional feature (compile-time macro)
//   REGFILE_BYPASS_EN : when defined, a read returns the post-update state of
//                       the same edge (value, busy and owner are forwarded).
//                       When undefined, a read returns the pre-update state
//                       and no forwarding path is built.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : synchronous, active-low reset; clears all state and outputs
//   rd_en      : per-port read enable
//   rd_addr    : read addresses, port i at [i*AW +: AW]
//   rd_value   : registered read value per port
//   rd_busy    : registered busy flag per port
//   rd_owner   : registered owner tag per port
//   alloc_en   : per-port allocation valid
//   alloc_reg  : allocation destination register per port
//   alloc_tag  : new owner tag per port
//   ret_en     : per-port retirement write valid
//   ret_reg    : retirement target register per port
//   ret_tag    : retiring instruction tag per port
//   ret_data   : retired value per port
//   flush      : clear all busy flags (misprediction recovery)
// ---------------------------------------------------------------------------
module register_status_file #(
    parameter int NUM_REGS    = 16,
    parameter int DATA_W      = 16,
    parameter int TAG_W       = 4,
    parameter int READ_PORTS  = 8,
    parameter int ALLOC_PORTS = 2,
    parameter int WRITE_PORTS = 3,
    parameter int AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [READ_PORTS-1:0]         rd_en,
    input  logic [READ_PORTS*AW-1:0]      rd_addr,
    output logic [READ_PORTS*DATA_W-1:0]  rd_value,
    output logic [READ_PORTS-1:0]         rd_busy,
    output logic [READ_PORTS*TAG_W-1:0]   rd_owner,
    input  logic [ALLOC_PORTS-1:0]        alloc_en,
    input  logic [ALLOC_PORTS*AW-1:0]     alloc_reg,
    input  logic [ALLOC_PORTS*TAG_W-1:0]  alloc_tag,
    input  logic [WRITE_PORTS-1:0]        ret_en,
    input  logic [WRITE_PORTS*AW-1:0]     ret_reg,
    input  logic [WRITE_PORTS*TAG_W-1:0]  ret_tag,
    input  logic [WRITE_PORTS*DATA_W-1:0] ret_data,
    input  logic                          flush
);

    // One extra bit lets the range check work when NUM_REGS is a power of two.
    localparam logic [AW:0] REG_LIMIT = (AW + 1)'(NUM_REGS);

    // Non-power-of-two register counts leave addresses with no register behind them.
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < REG_LIMIT);
    endfunction

    logic [DATA_W-1:0] value_q [NUM_REGS];
    logic [DATA_W-1:0] value_d [NUM_REGS];
    logic [TAG_W-1:0]  owner_q [NUM_REGS];
    logic [TAG_W-1:0]  owner_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [READ_PORTS*DATA_W-1:0] rd_value_d;
    logic [READ_PORTS-1:0]        rd_busy_d;
    logic [READ_PORTS*TAG_W-1:0]  rd_owner_d;

    // Next register state. Ports are walked in ascending order so the
    // highest-indexed port wins a same-register conflict. Busy is resolved
    // in rising priority order: retire-clear, then allocate, then flush.
    // The retire ownership check looks at pre-edge state.
    always_comb begin
        logic [AW-1:0] r;
        value_d = value_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        r       = '0;

        for (int j = 0; j < WRITE_PORTS; j++) begin
            r = ret_reg[j*AW +: AW];
            if (ret_en[j] && in_range(r)) begin
                value_d[r] = ret_data[j*DATA_W +: DATA_W];
                if (busy_q[r] && (owner_q[r] == ret_tag[j*TAG_W +: TAG_W])) begin
                    busy_d[r] = 1'b0;
                end
            end
        end

        if (flush) begin
            busy_d = '0;
        end else begin
            for (int k = 0; k < ALLOC_PORTS; k++) begin
                r = alloc_reg[k*AW +: AW];
                if (alloc_en[k] && in_range(r)) begin
                    busy_d[r]  = 1'b1;
                    owner_d[r] = alloc_tag[k*TAG_W +: TAG_W];
                end
            end
        end
    end

    // Read data source. With bypass, reads see this edge's updates.
    always_comb begin
        logic [AW-1:0] a;
        rd_value_d = '0;
        rd_busy_d  = '0;
        rd_owner_d = '0;
        a          = '0;

        for (int i = 0; i < READ_PORTS; i++) begin
            a = rd_addr[i*AW +: AW];
            if (in_range(a)) begin
`ifdef REGFILE_BYPASS_EN
                rd_value_d[i*DATA_W +: DATA_W] = value_d[a];
                rd_busy_d[i]                   = busy_d[a];
                rd_owner_d[i*TAG_W +: TAG_W]   = owner_d[a];
`else
                rd_value_d[i*DATA_W +: DATA_W] = value_q[a];
                rd_busy_d[i]                   = busy_q[a];
                rd_owner_d[i*TAG_W +: TAG_W]   = owner_q[a];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                value_q[r] <= '0;
                owner_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    // Read ports that are not enabled keep their previous result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_value <= '0;
            rd_busy  <= '0;
            rd_owner <= '0;
        end else begin
            for (int i = 0; i < READ_PORTS; i++) begin
                if (rd_en[i]) begin
                    rd_value[i*DATA_W +: DATA_W] <= rd_value_d[i*DATA_W +: DATA_W];
                    rd_busy[i]                   <= rd_busy_d[i];
                    rd_owner[i*TAG_W +: TAG_W]   <= rd_owner_d[i*TAG_W +: TAG_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_status_file.sv
// ---------------------------------------------------------------------------
// tb_register_status_file
//
// Directed bench for register_status_file with the default parameters.
// Stimulus pushes the hand-computed read result of every enabled read port
// into a scoreboard queue. A monitor captures rd_en at each rising edge and,
// on the following falling edge, pops one entry per enabled port and compares
// it against the DUT outputs. Expected values for the same-cycle bypass
// vectors follow REGFILE_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_register_status_file;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;
    localparam int TAG_W    = 4;
    localparam int RP       = 8;
    localparam int AP       = 2;
    localparam int WP       = 3;
    localparam int AW       = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [RP-1:0]        rd_en;
    logic [RP*AW-1:0]     rd_addr;
    logic [RP*DATA_W-1:0] rd_value;
    logic [RP-1:0]        rd_busy;
    logic [RP*TAG_W-1:0]  rd_owner;
    logic [AP-1:0]        alloc_en;
    logic [AP*AW-1:0]     alloc_reg;
    logic [AP*TAG_W-1:0]  alloc_tag;
    logic [WP-1:0]        ret_en;
    logic [WP*AW-1:0]     ret_reg;
    logic [WP*TAG_W-1:0]  ret_tag;
    logic [WP*DATA_W-1:0] ret_data;
    logic                 flush;

    typedef struct {
        int                port;
        logic [DATA_W-1:0] value;
        logic              busy;
        logic [TAG_W-1:0]  owner;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    register_status_file #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .READ_PORTS(RP), .ALLOC_PORTS(AP), .WRITE_PORTS(WP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_value(rd_value), .rd_busy(rd_busy), .rd_owner(rd_owner),
        .alloc_en(alloc_en), .alloc_reg(alloc_reg), .alloc_tag(alloc_tag),
        .ret_en(ret_en), .ret_reg(ret_reg), .ret_tag(ret_tag), .ret_data(ret_data),
        .flush(flush)
    );

    // Monitor: one scoreboard entry per read port enabled at the last edge.
    initial begin
        logic [RP-1:0] cap;
        exp_t          e;
        forever begin
            @(posedge clk);
            cap = rd_en;
            @(negedge clk);
            for (int i = 0; i < RP; i++) begin
                if (cap[i]) begin
                    tests_run++;
                    if (sb.size() == 0) begin
                        tests_failed++;
                        $display("[TB] FAIL read_port%0d: no expected entry, got value=%h busy=%b owner=%h",
                                 i, rd_value[i*DATA_W +: DATA_W], rd_busy[i], rd_owner[i*TAG_W +: TAG_W]);
                    end else begin
                        e = sb.pop_front();
                        if (e.port != i ||
                            rd_value[i*DATA_W +: DATA_W] !== e.value ||
                            rd_busy[i] !== e.busy ||
                            rd_owner[i*TAG_W +: TAG_W] !== e.owner) begin
                            tests_failed++;
                            $display("[TB] FAIL read_port%0d @%0t: got value=%h busy=%b owner=%h, expected port%0d value=%h busy=%b owner=%h",
                                     i, $time, rd_value[i*DATA_W +: DATA_W], rd_busy[i],
                                     rd_owner[i*TAG_W +: TAG_W], e.port, e.value, e.busy, e.owner);
                        end
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        rd_en    = '0;
        alloc_en = '0;
        ret_en   = '0;
        flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        clear_inputs();
    endtask

    task automatic apply_stimulus(input int port, input int addr,
                                  input logic [DATA_W-1:0] v, input logic b,
                                  input logic [TAG_W-1:0] o);
        exp_t e;
        rd_en[port]              = 1'b1;
        rd_addr[port*AW +: AW]   = AW'(addr);
        e.port  = port;
        e.value = v;
        e.busy  = b;
        e.owner = o;
        sb.push_back(e);
    endtask

    task automatic do_alloc(input int k, input int r, input int tag);
        alloc_en[k]               = 1'b1;
        alloc_reg[k*AW +: AW]     = AW'(r);
        alloc_tag[k*TAG_W +: TAG_W] = TAG_W'(tag);
    endtask

    task automatic do_retire(input int j, input int r, input int tag,
                             input logic [DATA_W-1:0] d);
        ret_en[j]                   = 1'b1;
        ret_reg[j*AW +: AW]         = AW'(r);
        ret_tag[j*TAG_W +: TAG_W]   = TAG_W'(tag);
        ret_data[j*DATA_W +: DATA_W] = d;
    endtask

    // Direct check for a port whose rd_en was low (its output must hold).
    task automatic check_output(input string name, input int port,
                                input logic [DATA_W-1:0] v, input logic b,
                                input logic [TAG_W-1:0] o);
        tests_run++;
        if (rd_value[port*DATA_W +: DATA_W] !== v || rd_busy[port] !== b ||
            rd_owner[port*TAG_W +: TAG_W] !== o) begin
            tests_failed++;
            $display("[TB] FAIL %s: got value=%h busy=%b owner=%h, expected value=%h busy=%b owner=%h",
                     name, rd_value[port*DATA_W +: DATA_W], rd_busy[port],
                     rd_owner[port*TAG_W +: TAG_W], v, b, o);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rd_addr   = '0;
        alloc_reg = '0;
        alloc_tag = '0;
        ret_reg   = '0;
        ret_tag   = '0;
        ret_data  = '0;
        clear_inputs();

        // Reset held two cycles with everything active: outputs stay zero.
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < RP; p++) apply_stimulus(p, p, 16'h0000, 1'b0, 4'h0);
            do_alloc(0, 5, 3);
            do_alloc(1, 6, 4);
            do_retire(0, 5, 3, 16'hDEAD);
            do_retire(1, 5, 3, 16'hCAFE);
            do_retire(2, 6, 4, 16'hF00D);
            flush = 1'b1;
            step();
        end
        rst_n = 1'b1;

        apply_stimulus(0, 5, 16'h0000, 1'b0, 4'h0);
        apply_stimulus(7, 5, 16'h0000, 1'b0, 4'h0);
        step();

        // Allocate then retire with the owning tag.
        do_alloc(0, 3, 7);
        step();
        apply_stimulus(1, 3, 16'h0000, 1'b1, 4'h7);
        step();
        do_retire(1, 3, 7, 16'hBEEF);
        step();
        apply_stimulus(2, 3, 16'hBEEF, 1'b0, 4'h7);
        step();

        // Stale retire: value written, register stays busy under the new owner.
        do_alloc(0, 3, 2);
        step();
        do_alloc(1, 3, 9);
        step();
        do_retire(0, 3, 2, 16'h1234);
        step();
        apply_stimulus(3, 3, 16'h1234, 1'b1, 4'h9);
        step();

        // Allocate overrides retire-clear; highest port wins on conflicts.
        do_alloc(0, 4, 5);
        step();
        do_alloc(1, 4, 5);
        do_retire(1, 4, 5, 16'h00AA);
        do_retire(0, 6, 0, 16'h1111);
        do_retire(2, 6, 0, 16'h2222);
        step();
        do_alloc(0, 10, 1);
        do_alloc(1, 10, 12);
        step();
        apply_stimulus(4, 4, 16'h00AA, 1'b1, 4'h5);
        apply_stimulus(5, 6, 16'h2222, 1'b0, 4'h0);
        apply_stimulus(6, 10, 16'h0000, 1'b1, 4'hC);
        step();

        // Flush: busy all cleared, allocation ignored, retire value kept.
        do_alloc(0, 2, 6);
        do_alloc(1, 8, 11);
        step();
        flush = 1'b1;
        do_alloc(0, 1, 3);
        do_retire(0, 9, 0, 16'h9999);
        step();
        apply_stimulus(0, 1, 16'h0000, 1'b0, 4'h0);
        apply_stimulus(1, 2, 16'h0000, 1'b0, 4'h6);
        apply_stimulus(2, 8, 16'h0000, 1'b0, 4'hB);
        apply_stimulus(3, 3, 16'h1234, 1'b0, 4'h9);
        apply_stimulus(4, 4, 16'h00AA, 1'b0, 4'h5);
        apply_stimulus(5, 9, 16'h9999, 1'b0, 4'h0);
        apply_stimulus(6, 10, 16'h0000, 1'b0, 4'hC);
        step();
        do_retire(0, 2, 6, 16'h7777);
        do_retire(1, 8, 11, 16'h8888);
        step();
        apply_stimulus(1, 2, 16'h7777, 1'b0, 4'h6);
        apply_stimulus(2, 8, 16'h8888, 1'b0, 4'hB);
        step();

        // Disabled read port holds while its register changes underneath.
        do_retire(0, 2, 6, 16'h1212);
        rd_addr[1*AW +: AW] = 4'd2;
        step();
        @(negedge clk);
        check_output("hold_port1", 1, 16'h7777, 1'b0, 4'h6);
        check_output("hold_port2", 2, 16'h8888, 1'b0, 4'hB);
        apply_stimulus(1, 2, 16'h1212, 1'b0, 4'h6);
        step();

        // Same-cycle read of a register being updated.
        do_retire(0, 7, 0, 16'h5A5A);
        do_alloc(1, 11, 13);
`ifdef REGFILE_BYPASS_EN
        apply_stimulus(6, 7, 16'h5A5A, 1'b0, 4'h0);
        apply_stimulus(7, 11, 16'h0000, 1'b1, 4'hD);
`else
        apply_stimulus(6, 7, 16'h0000, 1'b0, 4'h0);
        apply_stimulus(7, 11, 16'h0000, 1'b0, 4'h0);
`endif
        step();
        apply_stimulus(6, 7, 16'h5A5A, 1'b0, 4'h0);
        apply_stimulus(7, 11, 16'h0000, 1'b1, 4'hD);
        step();

        // Reset in the middle of flush and allocation wins over both.
        rst_n = 1'b0;
        flush = 1'b1;
        do_alloc(0, 3, 4);
        do_retire(0, 3, 4, 16'hABCD);
        apply_stimulus(0, 3, 16'h0000, 1'b0, 4'h0);
        step();
        rst_n = 1'b1;
        apply_stimulus(0, 3, 16'h0000, 1'b0, 4'h0);
        apply_stimulus(1, 7, 16'h0000, 1'b0, 4'h0);
        apply_stimulus(2, 2, 16'h0000, 1'b0, 4'h0);
        step();

        // Drain: bounded wait for the monitor to consume every entry.
        for (int c = 0; c < 4 && sb.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d expected reads never observed, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_status_file.md
# register_status_file

Parametrised architectural register file with per-register rename status (busy flag plus owner tag), sitting between dispatch/instruction buffer and retirement. It serves READ_PORTS registered reads of value/busy/owner, accepts ALLOC_PORTS dispatch allocations that mark destinations busy under a new owner tag, and WRITE_PORTS retirement writes that update values and clear busy only when the retiring tag still owns the register. A flush input drops all in-flight ownership on misprediction.

## Interface
- NUM_REGS, 16, architectural registers; AW = $clog2(NUM_REGS)
- DATA_W, 16, register value width
- TAG_W, 4, owner (ROB) tag width
- READ_PORTS, 8, read ports
- ALLOC_PORTS, 2, dispatch allocation ports
- WRITE_PORTS, 3, retirement write ports
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_en  in  READ_PORTS  per-port read enable
- rd_addr  in  READ_PORTS*AW  read addresses, port i at [i*AW +: AW]
- rd_value  out  READ_PORTS*DATA_W  registered read value
- rd_busy  out  READ_PORTS  registered busy flag
- rd_owner  out  READ_PORTS*TAG_W  registered owner tag
- alloc_en  in  ALLOC_PORTS  allocation valid
- alloc_reg  in  ALLOC_PORTS*AW  destination register
- alloc_tag  in  ALLOC_PORTS*TAG_W  new owner tag
- ret_en  in  WRITE_PORTS  retirement write valid
- ret_reg  in  WRITE_PORTS*AW  target register
- ret_tag  in  WRITE_PORTS*TAG_W  retiring instruction tag
- ret_data  in  WRITE_PORTS*DATA_W  retired value
- flush  in  1  clear all busy flags

## Operation
- State per register: value[DATA_W], busy, owner[TAG_W].
- Read: rd_en[i] high -> outputs for port i load value/busy/owner of rd_addr[i] at next edge; rd_en[i] low -> port i outputs hold.
- Retire: ret_en[j] -> value[ret_reg[j]] <= ret_data[j] unconditionally; busy cleared only if busy && owner == ret_tag[j]; owner unchanged.
- Allocate: alloc_en[k] -> busy[alloc_reg[k]] <= 1, owner <= alloc_tag[k].
- Priority per register, same cycle: flush > allocate > retire-clear for busy; allocate overrides retire-clear (register stays busy with new tag, value still written).
- Multiple ports same register: highest port index wins (retire value, allocation tag).
- Flush: all busy <= 0 next edge; allocations in flush cycle ignored; retire value writes still performed; owners unchanged.
- Read results reflect state before the current edge's updates unless REGFILE_BYPASS_EN.
- Out-of-range addresses (NUM_REGS not power of two): reads return 0/0/0; writes/allocs ignored.

## Timing
- Read latency 1 cycle; no stalls, no handshake; all ports fully concurrent.
- Allocation/retire visible to reads issued the following cycle (2-cycle observation from the update edge without bypass).
- rst_n low at an edge: all value, busy, owner, rd_value, rd_busy, rd_owner <= 0; overrides every other input, including mid-flush or mid-allocation.
- First edge after rst_n high operates normally.

## Configuration
- REGFILE_BYPASS_EN defined: read in the same cycle as an update to the same register returns post-update state: retire value forwarded (highest matching port), busy/owner reflect allocate/retire-clear/flush with the priorities above; effective read-after-write latency 1 cycle.
- Not defined: reads return pre-update state; no forwarding logic synthesised.

## Test plan
- Reset: hold rst_n=0 two cycles with rd_en all 1, alloc_en/ret_en active -> all rd_* outputs 0, r5 reads value 0 busy 0 owner 0 afterwards.
- Alloc r3 tag 7, next cycle read r3 -> rd_busy=1, rd_owner=7; retire r3 tag 7 data 0xBEEF, read -> value 0xBEEF, busy 0.
- Stale retire: alloc r3 tag 2, then alloc r3 tag 9, retire r3 tag 2 data 0x1234 -> value 0x1234, busy 1, owner 9.
- Same-cycle alloc r4 tag 5 and retire r4 tag 5 (r4 owned by 5) data 0x00AA -> busy 1, owner 5, value 0x00AA; ret ports 0/2 both to r6 data 0x1111/0x2222 -> r6=0x2222.
- Flush with alloc r1 tag 3 and r2,r8 busy -> all busy 0, r1 owner unchanged; following retire with old tags changes value only.
- Bypass: with REGFILE_BYPASS_EN, retire r7 0x5A5A and read r7 same cycle -> rd_value 0x5A5A next edge; without macro -> old value, 0x5A5A one cycle later.
